// File: rtl/dump_fsm.sv
// dump_fsm: output-side controller of the SHAKE core.
// It streams each squeezed rate block out of the PISO buffer one word per
// accepted beat, and counts down the requested output length. When the job
// needs another block, it hands the buffer back and requests a squeeze.
// It flags the final word and reports how many of its bits are valid.
//
// Ports
//   clk                    clock, rising edge
//   rst                    asynchronous reset, active-high
//   start                  1-cycle job start; samples output_length and mode
//   output_length          total output bits requested
//   mode                   0 = SHAKE128, 1 = SHAKE256
//   output_buffer_full     PISO holds a fresh squeezed block
//   ready_in               downstream accepts a word this cycle
//   valid_out              current PISO word is valid
//   last_out               current word is the final word of the job
//   last_word_bits         valid bits in the final word, 0 otherwise
//   dump_enable            PISO shift enable, one per accepted beat
//   output_buffer_empty_wr pulse: block consumed, PISO free
//   squeeze_req_wr         pulse: permutation must squeeze another block
//   done                   pulse: job complete
//
// state      | meaning
// IDLE       | waiting for start
// WAIT_BLOCK | waiting for the PISO to hold a squeezed block
// DUMP       | streaming words of the current block
// FINISH     | one-cycle done pulse, then back to IDLE

module dump_fsm #(
    parameter int W       = 64,
    parameter int LEN_W   = 32,
    parameter int RATE128 = 21,
    parameter int RATE256 = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       output_length,
    input  logic                   mode,
    input  logic                   output_buffer_full,
    input  logic                   ready_in,
    output logic                   valid_out,
    output logic                   last_out,
    output logic [$clog2(W+1)-1:0] last_word_bits,
    output logic                   dump_enable,
    output logic                   output_buffer_empty_wr,
    output logic                   squeeze_req_wr,
    output logic                   done
);

    localparam int RATE_MAX = (RATE128 > RATE256) ? RATE128 : RATE256;
    localparam int CNT_W    = $clog2(RATE_MAX + 1);
    localparam int BITS_W   = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLOCK,
        DUMP,
        FINISH
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   remaining_nxt;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   word_cnt_nxt;
    logic [CNT_W-1:0]   rate_words;
    logic [CNT_W-1:0]   rate_words_nxt;
    logic               is_last;
    logic               block_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            word_cnt   <= '0;
            rate_words <= CNT_W'(RATE128);
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            word_cnt   <= word_cnt_nxt;
            rate_words <= rate_words_nxt;
        end
    end

    always_comb begin
        state_nxt              = state;
        remaining_nxt          = remaining;
        word_cnt_nxt           = word_cnt;
        rate_words_nxt         = rate_words;
        valid_out              = 1'b0;
        last_out               = 1'b0;
        last_word_bits         = '0;
        dump_enable            = 1'b0;
        output_buffer_empty_wr = 1'b0;
        squeeze_req_wr         = 1'b0;
        done                   = 1'b0;
        is_last                = (remaining <= LEN_W'(W));
        block_end              = (word_cnt == rate_words - CNT_W'(1));

        case (state)
            IDLE: begin
                if (start) begin
                    remaining_nxt  = output_length;
                    rate_words_nxt = mode ? CNT_W'(RATE256) : CNT_W'(RATE128);
                    state_nxt      = (output_length == '0) ? FINISH : WAIT_BLOCK;
                end
            end
            WAIT_BLOCK: begin
                word_cnt_nxt = '0;
                if (output_buffer_full) begin
                    state_nxt = DUMP;
                end
            end
            DUMP: begin
                valid_out = 1'b1;
                last_out  = is_last;
                if (is_last) begin
                    // remaining <= W here, so it fits the bit-count field
                    last_word_bits = remaining[BITS_W-1:0];
                end
                if (ready_in) begin
                    dump_enable   = 1'b1;
                    word_cnt_nxt  = word_cnt + CNT_W'(1);
                    remaining_nxt = is_last ? '0 : remaining - LEN_W'(W);
                    // the final word wins over the block boundary: no squeeze
                    if (is_last) begin
                        output_buffer_empty_wr = 1'b1;
                        state_nxt              = FINISH;
                    end else if (block_end) begin
                        output_buffer_empty_wr = 1'b1;
                        squeeze_req_wr         = 1'b1;
                        state_nxt              = WAIT_BLOCK;
                    end
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dump_fsm.sv
// Testbench for dump_fsm: jobs are issued with an expected beat list pushed
// into a queue; a monitor pops one entry per accepted beat and compares.
module tb_dump_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] output_length;
    logic        mode;
    logic        output_buffer_full;
    logic        ready_in;
    logic        valid_out;
    logic        last_out;
    logic [6:0]  last_word_bits;
    logic        dump_enable;
    logic        output_buffer_empty_wr;
    logic        squeeze_req_wr;
    logic        done;

    dump_fsm dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .output_length          (output_length),
        .mode                   (mode),
        .output_buffer_full     (output_buffer_full),
        .ready_in               (ready_in),
        .valid_out              (valid_out),
        .last_out               (last_out),
        .last_word_bits         (last_word_bits),
        .dump_enable            (dump_enable),
        .output_buffer_empty_wr (output_buffer_empty_wr),
        .squeeze_req_wr         (squeeze_req_wr),
        .done                   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit last;
        int bits;
        bit blk_end;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    done_cnt = 0;
    int    empty_cnt = 0;
    int    job_beats = 0;
    int    bp_at = 0;
    int    bp_cnt = 0;
    int    start_inj = 0;
    bit    fin_inj = 0;
    bit    rnd_ready = 0;
    bit    zero_pending = 0;
    bit    done_due = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: actual %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: a job of len bits is ceil(len/64) words, rate words per block.
    function automatic void push_job(input bit m, input int len);
        int rate;
        int words;
        rate  = m ? 17 : 21;
        words = (len + 63) / 64;
        for (int i = 0; i < words; i++) begin
            beat_t b;
            b.last    = (i == words - 1);
            b.bits    = b.last ? len - 64 * (words - 1) : 0;
            b.blk_end = ((i % rate) == rate - 1);
            exp_q.push_back(b);
        end
    endfunction

    // Background driver: downstream ready and injected start pulses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (start_inj == 2) begin
                start     = 1'b0;
                start_inj = 0;
            end else if (start_inj == 1) begin
                start         = 1'b1;
                output_length = 32'd8;
                start_inj     = 2;
            end
            if (bp_cnt > 0) begin
                ready_in = 1'b0;
                bp_cnt--;
            end else begin
                ready_in = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        bit    beat;
        bit    nxt_due;
        beat_t e;
        if (rst) begin
            done_due = 1'b0;
        end else begin
            chk("done_timing", done, done_due);
            if (done) done_cnt++;
            if (output_buffer_empty_wr) empty_cnt++;
            nxt_due = start && zero_pending;
            beat    = valid_out && ready_in;
            chk("dump_enable", dump_enable, beat);
            if (valid_out && exp_q.size() == 0) begin
                chk("valid_without_job", valid_out, 0);
            end else if (valid_out) begin
                e = exp_q[0];
                chk("last_out", last_out, e.last);
                chk("last_word_bits", last_word_bits, e.bits);
                if (beat) begin
                    void'(exp_q.pop_front());
                    chk("empty_wr", output_buffer_empty_wr, e.last || e.blk_end);
                    chk("squeeze_req", squeeze_req_wr, e.blk_end && !e.last);
                    job_beats++;
                    if (e.last) begin
                        nxt_due = 1'b1;
                        if (fin_inj) start_inj = 1;
                    end
                    if (bp_at != 0 && job_beats == bp_at) begin
                        bp_cnt    = 3;
                        start_inj = 1;
                    end
                end
            end else begin
                chk("idle_last_out", last_out, 0);
                chk("idle_bits", last_word_bits, 0);
            end
            if (!beat) begin
                chk("stray_empty_wr", output_buffer_empty_wr, 0);
                chk("stray_squeeze", squeeze_req_wr, 0);
            end
            done_due = nxt_due;
        end
    end

    // variant: 0 plain, 1 backpressure after beat 2 + mid-job start,
    //          2 start pulse during the done cycle
    task automatic run_job(input bit m, input int len, input bit rr, input int variant);
        int rate;
        int words;
        int blocks;
        int d0;
        int e0;
        int t;
        int dly;
        rate      = m ? 17 : 21;
        words     = (len + 63) / 64;
        blocks    = (words + rate - 1) / rate;
        rnd_ready = rr;
        job_beats = 0;
        bp_at     = (variant == 1) ? 2 : 0;
        fin_inj   = (variant == 2);
        push_job(m, len);
        d0 = done_cnt;
        @(posedge clk);
        #1;
        mode          = m;
        output_length = len;
        start         = 1'b1;
        zero_pending  = (len == 0);
        @(posedge clk);
        #1;
        start        = 1'b0;
        zero_pending = 1'b0;
        for (int b = 0; b < blocks; b++) begin
            dly = $urandom_range(0, 3);
            for (int k = 0; k < dly; k++) begin
                @(posedge clk);
                #1;
            end
            e0 = empty_cnt;
            output_buffer_full = 1'b1;
            @(negedge clk);
            chk("latency_wait", valid_out, 0);
            @(negedge clk);
            chk("latency_first", valid_out, 1);
            t = 0;
            while (empty_cnt == e0 && t < 3000) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("empty_wr_seen", empty_cnt != e0, 1);
            output_buffer_full = 1'b0;
            @(posedge clk);
            #1;
        end
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("done_count", done_cnt - d0, 1);
        chk("beats_total", job_beats, words);
        chk("queue_drained", exp_q.size(), 0);
        rnd_ready = 0;
        bp_at     = 0;
        fin_inj   = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_in_dump();
        int t;
        int d0;
        rnd_ready = 0;
        job_beats = 0;
        push_job(1, 256);
        @(posedge clk);
        #1;
        mode          = 1'b1;
        output_length = 32'd256;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start              = 1'b0;
        output_buffer_full = 1'b1;
        t = 0;
        while (!valid_out && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rst_reached_dump", valid_out, 1);
        d0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_dump_enable", dump_enable, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_empty_wr", output_buffer_empty_wr, 0);
        chk("rst_squeeze", squeeze_req_wr, 0);
        exp_q.delete();
        output_buffer_full = 1'b0;
        for (int k = 0; k < 2; k++) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_valid", valid_out, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int len;
        rst                = 1'b1;
        start              = 1'b0;
        output_length      = '0;
        mode               = 1'b0;
        output_buffer_full = 1'b0;
        ready_in           = 1'b1;
        #1;
        chk("reset_valid_out", valid_out, 0);
        chk("reset_last_out", last_out, 0);
        chk("reset_bits", last_word_bits, 0);
        chk("reset_dump_enable", dump_enable, 0);
        chk("reset_empty_wr", output_buffer_empty_wr, 0);
        chk("reset_squeeze", squeeze_req_wr, 0);
        chk("reset_done", done, 0);
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        rst = 1'b0;

        run_job(1'b1, 256, 1'b0, 0);
        run_job(1'b0, 100, 1'b0, 2);
        run_job(1'b0, 1345, 1'b0, 0);
        run_job(1'b1, 1088, 1'b0, 0);
        run_job(1'b1, 256, 1'b0, 1);
        run_job(1'b0, 0, 1'b0, 0);
        reset_in_dump();
        run_job(1'b1, 64, 1'b0, 0);

        for (int j = 0; j < 40; j++) begin
            m = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(0, 3000);
                1:       len = 64 * $urandom_range(1, 45);
                2:       len = 64 * (m ? 17 : 21) * $urandom_range(1, 2) + $urandom_range(0, 2) * 32 - 32;
                default: len = $urandom_range(1, 130);
            endcase
            if (len < 0) len = 0;
            run_job(m[0], len, 1'b1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
